// File: rtl/bram_fifo_ctrl_if.sv
// Bus bundle between the FWFT FIFO controller, its producer/consumer pair and
// the simple dual-port BRAM it sequences.
//   slave  : controller view (takes wr_valid/wr_data/rd_ready/mem_dout,
//            drives handshakes, occupancy and BRAM port controls)
//   master : environment view (producer, consumer and BRAM side)
interface bram_fifo_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 8
);
  // producer side
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  // consumer side
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  // occupancy
  logic [ADDR_WIDTH:0]   count;
  // BRAM ports
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr_w;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [DATA_WIDTH-1:0] mem_dout;

  modport slave (
    input  wr_valid, wr_data, rd_ready, mem_dout,
    output wr_ready, rd_valid, rd_data, count,
           mem_we, mem_addr_w, mem_din, mem_addr_r
  );

  modport master (
    output wr_valid, wr_data, rd_ready, mem_dout,
    input  wr_ready, rd_valid, rd_data, count,
           mem_we, mem_addr_w, mem_din, mem_addr_r
  );
endinterface

// File: rtl/bram_fifo_ctrl.sv
// First-word-fall-through FIFO controller around an external simple
// dual-port BRAM (registered read, 1-cycle latency, no read enable).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, discards all contents
//   bus   : bram_fifo_ctrl_if.slave -- wr_valid/wr_ready/wr_data from the
//           producer, rd_valid/rd_ready/rd_data to the consumer, count
//           (0..DEPTH), and mem_we/mem_addr_w/mem_din/mem_addr_r/mem_dout
//           to the BRAM. rd_data is mem_dout, mem_din is wr_data.
module bram_fifo_ctrl #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  bram_fifo_ctrl_if.slave       bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         mem_cnt;    // written but not yet fetched
  logic                  out_valid;  // mem_dout holds an unconsumed head word

  logic [CW-1:0]         count_c;
  logic                  full_c;
  logic                  push_c;
  logic                  pop_c;
  logic                  fetch_c;
  logic [DATA_WIDTH-1:0] head_data_c;

  // Occupancy and handshake decode
  always_comb begin
    count_c = mem_cnt + CW'(out_valid);
    full_c  = (count_c == CW'(DEPTH));
    push_c  = bus.wr_valid && !full_c;
    pop_c   = out_valid && bus.rd_ready;
    // Fetch the next word when the output register is free or being drained.
    fetch_c = (mem_cnt != '0) && (!out_valid || bus.rd_ready);
  end

  assign head_data_c = bus.mem_dout;

  assign bus.wr_ready   = !full_c;
  assign bus.rd_valid   = out_valid;
  assign bus.rd_data    = head_data_c;
  assign bus.count      = count_c;
  assign bus.mem_we     = push_c;
  assign bus.mem_addr_w = wr_ptr;
  assign bus.mem_din    = bus.wr_data;
  // Without a fetch, re-read the head slot so mem_dout holds across stalls;
  // that slot still counts toward full, so it can never be overwritten.
  assign bus.mem_addr_r = fetch_c ? rd_ptr : rd_ptr - ADDR_WIDTH'(1);

  // Pointer, occupancy and output-valid state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= '0;
      out_valid <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr + ADDR_WIDTH'(push_c);
      rd_ptr  <= rd_ptr + ADDR_WIDTH'(fetch_c);
      mem_cnt <= mem_cnt + CW'(push_c) - CW'(fetch_c);
      if (fetch_c) begin
        out_valid <= 1'b1;
      end else if (pop_c) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Directed and randomized bench for bram_fifo_ctrl with a behavioural BRAM.
module tb_bram_fifo_ctrl;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 8;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  bram_fifo_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  bram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Simple dual-port BRAM: registered read, no read enable
  logic [DW-1:0] mem [8];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr_w] <= bus.mem_din;
    bus.mem_dout <= mem[bus.mem_addr_r];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] q[$];
  int sent;
  int got;
  bit exp_full;
  bit exp_push;

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.rd_ready = 1'b0;
    #3;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Stall hold: A0 at slot 0, A1 at slot 1
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'hA0;
    #1;
    chk("st_mem_we", 32'(bus.mem_we), 32'd1);
    chk("st_addr_w", 32'(bus.mem_addr_w), 32'd0);
    tick();
    bus.wr_data = 8'hA1;
    #1;
    chk("st_lat_e0", 32'(bus.rd_valid), 32'd0);
    tick();
    bus.wr_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("st_hold_valid", 32'(bus.rd_valid), 32'd1);
      chk("st_hold_data", 32'(bus.rd_data), 32'hA0);
      chk("st_hold_addr_r", 32'(bus.mem_addr_r), 32'd0);
      chk("st_hold_count", 32'(bus.count), 32'd2);
      tick();
    end
    bus.rd_ready = 1'b1;
    #1;
    chk("st_pop0", 32'(bus.rd_data), 32'hA0);
    tick();
    #1;
    chk("st_pop1_valid", 32'(bus.rd_valid), 32'd1);
    chk("st_pop1", 32'(bus.rd_data), 32'hA1);
    tick();
    bus.rd_ready = 1'b0;
    #1;
    chk("st_empty_valid", 32'(bus.rd_valid), 32'd0);
    chk("st_empty_count", 32'(bus.count), 32'd0);
    tick();

    // Fill to DEPTH with no reads, then try a 9th write
    for (int i = 0; i < 8; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'(i + 1);
      #1;
      chk("fill_count", 32'(bus.count), 32'(i));
      chk("fill_wr_ready", 32'(bus.wr_ready), 32'd1);
      tick();
    end
    bus.wr_data = 8'h09;
    #1;
    chk("full_count", 32'(bus.count), 32'd8);
    chk("full_wr_ready", 32'(bus.wr_ready), 32'd0);
    chk("full_mem_we", 32'(bus.mem_we), 32'd0);
    chk("full_head", 32'(bus.rd_data), 32'h01);
    tick();
    bus.wr_valid = 1'b0;
    #1;
    chk("full_count_hold", 32'(bus.count), 32'd8);
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("drain_valid", 32'(bus.rd_valid), 32'd1);
      chk("drain_data", 32'(bus.rd_data), 32'(i + 1));
      tick();
    end
    bus.rd_ready = 1'b0;
    #1;
    chk("drain_empty", 32'(bus.rd_valid), 32'd0);
    chk("drain_count", 32'(bus.count), 32'd0);
    tick();

    // Full plus simultaneous write and read
    for (int i = 0; i < 8; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'(8'h31 + i);
      tick();
    end
    bus.wr_data  = 8'h39;
    bus.rd_ready = 1'b1;
    #1;
    chk("fp_count", 32'(bus.count), 32'd8);
    chk("fp_wr_ready", 32'(bus.wr_ready), 32'd0);
    chk("fp_mem_we", 32'(bus.mem_we), 32'd0);
    chk("fp_head", 32'(bus.rd_data), 32'h31);
    tick();
    bus.rd_ready = 1'b0;
    #1;
    chk("fp_count7", 32'(bus.count), 32'd7);
    chk("fp_wr_ready7", 32'(bus.wr_ready), 32'd1);
    chk("fp_mem_we7", 32'(bus.mem_we), 32'd1);
    tick();
    bus.wr_valid = 1'b0;
    #1;
    chk("fp_count8", 32'(bus.count), 32'd8);
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("fp_drain", 32'(bus.rd_data), 32'(8'h32 + i));
      tick();
    end
    bus.rd_ready = 1'b0;
    #1;
    chk("fp_empty", 32'(bus.rd_valid), 32'd0);
    tick();

    // Streaming 32 words with the consumer always ready
    sent = 0;
    got  = 0;
    bus.rd_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (sent < 32) begin
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'(sent);
      end else begin
        bus.wr_valid = 1'b0;
      end
      #1;
      if (bus.rd_valid) begin
        chk("stream_data", 32'(bus.rd_data), 32'(got));
        got++;
      end
      chk("stream_count_le2", 32'(bus.count <= 4'd2), 32'd1);
      if (bus.wr_valid && bus.wr_ready) sent++;
      tick();
    end
    chk("stream_total", 32'(got), 32'd32);
    bus.rd_ready = 1'b0;
    bus.wr_valid = 1'b0;

    // Reset mid-stream at count=5
    for (int i = 0; i < 5; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'(8'h50 + i);
      tick();
    end
    bus.wr_valid = 1'b0;
    #1;
    chk("mr_count5", 32'(bus.count), 32'd5);
    reset = 1'b1;
    #1;
    chk("mr_count", 32'(bus.count), 32'd0);
    chk("mr_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("mr_wr_ready", 32'(bus.wr_ready), 32'd1);
    tick();
    reset = 1'b0;
    tick();
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h11;
    #1;
    chk("mr_addr_w", 32'(bus.mem_addr_w), 32'd0);
    tick();
    bus.wr_valid = 1'b0;
    #1;
    chk("mr_lat1", 32'(bus.rd_valid), 32'd0);
    tick();
    #1;
    chk("mr_lat2", 32'(bus.rd_valid), 32'd1);
    chk("mr_data", 32'(bus.rd_data), 32'h11);
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    #1;
    chk("mr_empty", 32'(bus.count), 32'd0);
    tick();

    // Random valid/ready against a queue scoreboard, with varying bias
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      case ((c / 1000) % 3)
        0:       begin bus.wr_valid = ($urandom_range(0, 3) != 0); bus.rd_ready = ($urandom_range(0, 3) == 0); end
        1:       begin bus.wr_valid = ($urandom_range(0, 3) == 0); bus.rd_ready = ($urandom_range(0, 3) != 0); end
        default: begin bus.wr_valid = $urandom_range(0, 1) != 0;   bus.rd_ready = $urandom_range(0, 1) != 0; end
      endcase
      bus.wr_data = 8'($urandom);
      #1;
      exp_full = (q.size() == 8);
      exp_push = bus.wr_valid && !exp_full;
      chk("rnd_count", 32'(bus.count), 32'(q.size()));
      chk("rnd_wr_ready", 32'(bus.wr_ready), 32'(!exp_full));
      chk("rnd_mem_we", 32'(bus.mem_we), 32'(exp_push));
      if (q.size() == 0) chk("rnd_empty_valid", 32'(bus.rd_valid), 32'd0);
      if (bus.rd_valid && bus.rd_ready && q.size() != 0) begin
        chk("rnd_data", 32'(bus.rd_data), 32'(q[0]));
        void'(q.pop_front());
      end
      if (exp_push) q.push_back(bus.wr_data);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
